// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
//   pc_t          : byte PC for the default 10-bit ROM word address (12 bits)
//   fetch_entry_t : one queue entry {data, pc} for the default configuration
//   PC_STEP       : byte increment between sequential fetches
package ifetch_pkg;

   localparam int unsigned DATA_SIZE_DEF = 32;
   localparam int unsigned ADDR_SIZE_DEF = 10;
   localparam int unsigned PC_STEP       = 4;

   typedef logic [ADDR_SIZE_DEF+1:0] pc_t;

   typedef struct packed {
      logic [DATA_SIZE_DEF-1:0] data;
      pc_t                      pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a clear input, used to buffer fetched {data, pc} words.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push_i       : write wdata_i (ignored when full unless popping in the same cycle)
//   pop_i        : drop the head entry (ignored when empty)
//   clear_i      : empty the FIFO; reset has priority
//   rdata_o      : head entry, full_o / empty_o / count_o : occupancy
module fetch_fifo #(
   parameter int unsigned WIDTH = 44,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     clear_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CntW'(DEPTH));
   assign count_o = count_q;
   assign rdata_o = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: contents are only observable through count_q.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch stage feeding the IF/ID register.
// Issues sequential reads to a registered ROM (1-cycle latency), buffers the returned
// words with their PCs, and hands them to decode via inst_valid/inst_ready.
//   CLK, RESET              : clock, synchronous active-high reset
//   redirect, redirect_pc   : taken-branch restart; flushes queue and in-flight word
//   rom_req, rom_addr       : ROM read strobe and word address
//   rom_data                : ROM read data, valid the cycle after rom_req
//   inst_valid/ready/data/pc: head-of-queue handshake (data/pc forced to 0 when invalid)
//   count                   : occupied queue entries
module inst_prefetch_queue
   import ifetch_pkg::*;
#(
   parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
   parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF,
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned RESET_PC  = 0
) (
   input  logic                    CLK,
   input  logic                    RESET,
   input  logic                    redirect,
   input  logic [ADDR_SIZE+1:0]    redirect_pc,
   output logic                    rom_req,
   output logic [ADDR_SIZE-1:0]    rom_addr,
   input  logic [DATA_SIZE-1:0]    rom_data,
   output logic                    inst_valid,
   input  logic                    inst_ready,
   output logic [DATA_SIZE-1:0]    inst_data,
   output logic [ADDR_SIZE+1:0]    inst_pc,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PcW  = ADDR_SIZE + 2;
   localparam int unsigned CntW = $clog2(DEPTH) + 1;
   localparam int unsigned EntW = DATA_SIZE + PcW;

   logic [PcW-1:0]  fetch_pc_q, fetch_pc_d;
   logic [PcW-1:0]  pending_pc_q, pending_pc_d;
   logic            pending_q, pending_d;
   logic            issue;
   logic [CntW-1:0] occupancy;
   logic            fifo_empty;
   logic            unused_fifo_full;
   logic [1:0]      unused_redirect_lsbs;
   logic [EntW-1:0] fifo_rdata;

   // Count the in-flight word so a push can never land in a full queue.
   assign occupancy = count + CntW'(pending_q);
   assign issue     = !RESET && !redirect && (occupancy < CntW'(DEPTH));

   assign rom_req  = issue;
   assign rom_addr = fetch_pc_q[PcW-1:2];

   assign unused_redirect_lsbs = redirect_pc[1:0];

   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      pending_pc_d = pending_pc_q;
      pending_d    = issue;
      if (redirect) begin
         fetch_pc_d = {redirect_pc[PcW-1:2], 2'b00};
      end else if (issue) begin
         fetch_pc_d   = fetch_pc_q + PcW'(PC_STEP);
         pending_pc_d = fetch_pc_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         fetch_pc_q   <= PcW'(RESET_PC);
         pending_pc_q <= '0;
         pending_q    <= 1'b0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         pending_pc_q <= pending_pc_d;
         pending_q    <= pending_d;
      end
   end

   fetch_fifo #(
      .WIDTH (EntW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (RESET),
      .push_i  (pending_q && !redirect),
      .pop_i   (inst_valid && inst_ready),
      .clear_i (redirect),
      .wdata_i ({rom_data, pending_pc_q}),
      .rdata_o (fifo_rdata),
      .full_o  (unused_fifo_full),
      .empty_o (fifo_empty),
      .count_o (count)
   );

   assign inst_valid = !fifo_empty;
   assign inst_data  = inst_valid ? fifo_rdata[EntW-1:PcW] : '0;
   assign inst_pc    = inst_valid ? fifo_rdata[PcW-1:0]    : '0;

endmodule
